// File: rtl/atm_if.sv
// Front-end/display bundle of the ATM session controller.
// The card-reader/keypad side is the master; the controller is the slave.
interface atm_if;
    logic        card_inserted;
    logic        pin_entered;
    logic        transaction_selected;
    logic        transaction_processed;
    logic        card_ejected;
    logic        withdrawal_requested;
    logic        deposit_requested;
    logic        balance_requested;
    logic        card_eject;
    logic [3:0]  transaction;
    logic        withdrawal_completed;
    logic        deposit_completed;
    logic [15:0] old_balance;
    logic [15:0] new_balance;
    logic [15:0] mini_statement;

    modport master (
        output card_inserted, pin_entered, transaction_selected, transaction_processed,
               card_ejected, withdrawal_requested, deposit_requested, balance_requested,
        input  card_eject, transaction, withdrawal_completed, deposit_completed,
               old_balance, new_balance, mini_statement
    );

    modport slave (
        input  card_inserted, pin_entered, transaction_selected, transaction_processed,
               card_ejected, withdrawal_requested, deposit_requested, balance_requested,
        output card_eject, transaction, withdrawal_completed, deposit_completed,
               old_balance, new_balance, mini_statement
    );
endinterface

// File: rtl/atm_controller.sv
// ATM session FSM: card/PIN handling with lockout, transaction selection and
// single-account balance update. All outputs are registered.
//
// state       | meaning
// ------------+--------------------------------------------------------------
// S_IDLE      | no session; waiting for a card
// S_PIN_CHECK | card present; waiting for a valid PIN, counting failed cycles
// S_SELECT    | PIN accepted; waiting for a menu choice or cancel
// S_PROCESS   | transaction latched; waiting for back-end grant or cancel
// S_EJECT     | session over; ejecting card until user acknowledges
// S_LOCKED    | too many PIN failures; card retained until removed
module atm_controller #(
    parameter logic [15:0] INIT_BALANCE    = 16'd1000,
    parameter logic [15:0] WITHDRAW_AMOUNT = 16'd100,
    parameter logic [15:0] DEPOSIT_AMOUNT  = 16'd100,
    parameter int          MAX_PIN_TRIES   = 3
) (
    input  logic clk,
    input  logic reset,
    atm_if.slave atm
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PIN_CHECK = 3'd1,
        S_SELECT    = 3'd2,
        S_PROCESS   = 3'd3,
        S_EJECT     = 3'd4,
        S_LOCKED    = 3'd5
    } state_t;

    localparam logic [3:0] TX_NONE     = 4'b0000;
    localparam logic [3:0] TX_WITHDRAW = 4'b0001;
    localparam logic [3:0] TX_DEPOSIT  = 4'b0010;
    localparam logic [3:0] TX_BALANCE  = 4'b0100;
    localparam logic [7:0] TRIES_INIT  = 8'(MAX_PIN_TRIES);

    state_t      state_q, state_d;
    logic [7:0]  tries_left_q, tries_left_d;
    logic [3:0]  transaction_q, transaction_d;
    logic        card_eject_q, card_eject_d;
    logic        withdrawal_completed_q, withdrawal_completed_d;
    logic        deposit_completed_q, deposit_completed_d;
    logic [15:0] balance_q, balance_d;
    logic [15:0] old_balance_q, old_balance_d;
    logic [15:0] mini_statement_q, mini_statement_d;
    logic [16:0] deposit_sum;

    // 17-bit sum so a deposit that would pass 16'hFFFF is refused, not wrapped
    assign deposit_sum = {1'b0, balance_q} + {1'b0, DEPOSIT_AMOUNT};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q                <= S_IDLE;
            tries_left_q           <= TRIES_INIT;
            transaction_q          <= TX_NONE;
            card_eject_q           <= 1'b0;
            withdrawal_completed_q <= 1'b0;
            deposit_completed_q    <= 1'b0;
            balance_q              <= INIT_BALANCE;
            old_balance_q          <= INIT_BALANCE;
            mini_statement_q       <= 16'd0;
        end else begin
            state_q                <= state_d;
            tries_left_q           <= tries_left_d;
            transaction_q          <= transaction_d;
            card_eject_q           <= card_eject_d;
            withdrawal_completed_q <= withdrawal_completed_d;
            deposit_completed_q    <= deposit_completed_d;
            balance_q              <= balance_d;
            old_balance_q          <= old_balance_d;
            mini_statement_q       <= mini_statement_d;
        end
    end

    always_comb begin
        state_d                = state_q;
        tries_left_d           = tries_left_q;
        transaction_d          = transaction_q;
        withdrawal_completed_d = withdrawal_completed_q;
        deposit_completed_d    = deposit_completed_q;
        balance_d              = balance_q;
        old_balance_d          = old_balance_q;
        mini_statement_d       = mini_statement_q;

        case (state_q)
            S_IDLE: begin
                transaction_d = TX_NONE;
                tries_left_d  = TRIES_INIT;
                if (atm.card_inserted) begin
                    state_d                = S_PIN_CHECK;
                    withdrawal_completed_d = 1'b0;
                    deposit_completed_d    = 1'b0;
                end
            end

            S_PIN_CHECK: begin
                if (!atm.card_inserted) begin
                    state_d = S_IDLE;
                end else if (atm.pin_entered) begin
                    state_d = S_SELECT;
                end else if (tries_left_q <= 8'd1) begin
                    // terminal count: this failure is the last one allowed
                    state_d       = S_LOCKED;
                    tries_left_d  = 8'd0;
                    transaction_d = TX_NONE;
                end else begin
                    tries_left_d = tries_left_q - 8'd1;
                end
            end

            S_SELECT: begin
                if (atm.withdrawal_requested) begin
                    transaction_d = TX_WITHDRAW;
                    state_d       = S_PROCESS;
                end else if (atm.deposit_requested) begin
                    transaction_d = TX_DEPOSIT;
                    state_d       = S_PROCESS;
                end else if (atm.balance_requested || atm.transaction_selected) begin
                    transaction_d = TX_BALANCE;
                    state_d       = S_PROCESS;
                end else if (atm.card_ejected) begin
                    state_d = S_EJECT;
                end
            end

            S_PROCESS: begin
                if (atm.card_ejected) begin
                    state_d = S_EJECT;
                end else if (atm.transaction_processed) begin
                    state_d = S_EJECT;
                    case (transaction_q)
                        TX_WITHDRAW: begin
                            if (balance_q >= WITHDRAW_AMOUNT) begin
                                old_balance_d          = balance_q;
                                balance_d              = balance_q - WITHDRAW_AMOUNT;
                                withdrawal_completed_d = 1'b1;
                            end
                        end
                        TX_DEPOSIT: begin
                            if (!deposit_sum[16]) begin
                                old_balance_d       = balance_q;
                                balance_d           = deposit_sum[15:0];
                                deposit_completed_d = 1'b1;
                            end
                        end
                        TX_BALANCE: begin
                            old_balance_d    = balance_q;
                            mini_statement_d = balance_q;
                        end
                        default: ;
                    endcase
                end
            end

            S_EJECT: begin
                if (atm.card_ejected) begin
                    state_d       = S_IDLE;
                    transaction_d = TX_NONE;
                end
            end

            S_LOCKED: begin
                transaction_d = TX_NONE;
                if (atm.card_ejected && !atm.card_inserted) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d       = S_IDLE;
                transaction_d = TX_NONE;
            end
        endcase

        card_eject_d = (state_d == S_EJECT) || (state_d == S_LOCKED);
    end

    assign atm.card_eject           = card_eject_q;
    assign atm.transaction          = transaction_q;
    assign atm.withdrawal_completed = withdrawal_completed_q;
    assign atm.deposit_completed    = deposit_completed_q;
    assign atm.old_balance          = old_balance_q;
    assign atm.new_balance          = balance_q;
    assign atm.mini_statement       = mini_statement_q;

endmodule

// File: tb/tb_atm_controller.sv
// Directed bench: three controllers (balances 1000, 50, 16'hFF9B) share one
// stimulus stream; each is checked against hand-computed values.
module tb_atm_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic card_inserted, pin_entered, transaction_selected, transaction_processed;
    logic card_ejected, withdrawal_requested, deposit_requested, balance_requested;

    int checks = 0;
    int errors = 0;

    atm_if ifa ();
    atm_if ifb ();
    atm_if ifc ();

    assign ifa.card_inserted = card_inserted;  assign ifb.card_inserted = card_inserted;  assign ifc.card_inserted = card_inserted;
    assign ifa.pin_entered = pin_entered;      assign ifb.pin_entered = pin_entered;      assign ifc.pin_entered = pin_entered;
    assign ifa.transaction_selected = transaction_selected;   assign ifb.transaction_selected = transaction_selected;   assign ifc.transaction_selected = transaction_selected;
    assign ifa.transaction_processed = transaction_processed; assign ifb.transaction_processed = transaction_processed; assign ifc.transaction_processed = transaction_processed;
    assign ifa.card_ejected = card_ejected;    assign ifb.card_ejected = card_ejected;    assign ifc.card_ejected = card_ejected;
    assign ifa.withdrawal_requested = withdrawal_requested;   assign ifb.withdrawal_requested = withdrawal_requested;   assign ifc.withdrawal_requested = withdrawal_requested;
    assign ifa.deposit_requested = deposit_requested;         assign ifb.deposit_requested = deposit_requested;         assign ifc.deposit_requested = deposit_requested;
    assign ifa.balance_requested = balance_requested;         assign ifb.balance_requested = balance_requested;         assign ifc.balance_requested = balance_requested;

    atm_controller #(.INIT_BALANCE(16'd1000)) u_dut_a (.clk(clk), .reset(reset), .atm(ifa));
    atm_controller #(.INIT_BALANCE(16'd50))   u_dut_b (.clk(clk), .reset(reset), .atm(ifb));
    atm_controller #(.INIT_BALANCE(16'hFF9B)) u_dut_c (.clk(clk), .reset(reset), .atm(ifc));

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 withdraw, 1 deposit, 2 inquiry via transaction_selected only
    task automatic open_to_process(input int kind);
        card_inserted = 1'b1;
        tick();
        pin_entered = 1'b1;
        tick();
        pin_entered = 1'b0;
        withdrawal_requested = (kind == 0);
        deposit_requested    = (kind == 1);
        transaction_selected = (kind == 2);
        tick();
        withdrawal_requested = 1'b0;
        deposit_requested    = 1'b0;
        transaction_selected = 1'b0;
    endtask

    task automatic grant();
        transaction_processed = 1'b1;
        tick();
        transaction_processed = 1'b0;
    endtask

    task automatic eject();
        card_ejected  = 1'b1;
        card_inserted = 1'b0;
        tick();
        card_ejected = 1'b0;
        chk("eject_idle_ce", ifa.card_eject, 16'd0);
        chk("eject_idle_tx", ifa.transaction, 16'd0);
    endtask

    initial begin
        reset = 1'b0;
        card_inserted = 0; pin_entered = 0; transaction_selected = 0; transaction_processed = 0;
        card_ejected = 0; withdrawal_requested = 0; deposit_requested = 0; balance_requested = 0;
        #12;
        chk("rst_ce",   ifa.card_eject, 16'd0);
        chk("rst_tx",   ifa.transaction, 16'd0);
        chk("rst_wc",   ifa.withdrawal_completed, 16'd0);
        chk("rst_dc",   ifa.deposit_completed, 16'd0);
        chk("rst_old",  ifa.old_balance, 16'd1000);
        chk("rst_new",  ifa.new_balance, 16'd1000);
        chk("rst_mini", ifa.mini_statement, 16'd0);
        chk("rst_new_b", ifb.new_balance, 16'd50);
        reset = 1'b1;

        // withdrawal session
        open_to_process(0);
        chk("sel_tx", ifa.transaction, 16'b0001);
        chk("sel_ce", ifa.card_eject, 16'd0);
        grant();
        chk("wd_ce",  ifa.card_eject, 16'd1);
        chk("wd_tx",  ifa.transaction, 16'b0001);
        chk("wd_wc",  ifa.withdrawal_completed, 16'd1);
        chk("wd_old", ifa.old_balance, 16'd1000);
        chk("wd_new", ifa.new_balance, 16'd900);
        chk("wd_wc_b",  ifb.withdrawal_completed, 16'd0);
        chk("wd_new_b", ifb.new_balance, 16'd50);
        chk("wd_ce_b",  ifb.card_eject, 16'd1);
        chk("wd_new_c", ifc.new_balance, 16'hFF37);
        chk("wd_old_c", ifc.old_balance, 16'hFF9B);
        tick();
        chk("eject_hold_ce", ifa.card_eject, 16'd1);
        eject();
        chk("after_ej_new", ifa.new_balance, 16'd900);

        // PIN lockout after three failed cycles
        card_inserted = 1'b1;
        tick();
        tick();
        tick();
        chk("pin_fail2_ce", ifa.card_eject, 16'd0);
        tick();
        chk("locked_ce",  ifa.card_eject, 16'd1);
        chk("locked_tx",  ifa.transaction, 16'd0);
        chk("locked_new", ifa.new_balance, 16'd900);
        card_ejected = 1'b1;
        tick();
        chk("locked_hold_ce", ifa.card_eject, 16'd1);
        card_inserted = 1'b0;
        tick();
        card_ejected = 1'b0;
        chk("unlock_ce", ifa.card_eject, 16'd0);

        // three deposits: C reaches exactly 16'hFFFF then refuses the third
        open_to_process(1);
        chk("dep1_tx", ifa.transaction, 16'b0010);
        grant();
        chk("dep1_dc",  ifa.deposit_completed, 16'd1);
        chk("dep1_wc",  ifa.withdrawal_completed, 16'd0);
        chk("dep1_old", ifa.old_balance, 16'd900);
        chk("dep1_new", ifa.new_balance, 16'd1000);
        chk("dep1_new_b", ifb.new_balance, 16'd150);
        chk("dep1_new_c", ifc.new_balance, 16'hFF9B);
        eject();
        open_to_process(1);
        grant();
        chk("dep2_new",   ifa.new_balance, 16'd1100);
        chk("dep2_dc_c",  ifc.deposit_completed, 16'd1);
        chk("dep2_new_c", ifc.new_balance, 16'hFFFF);
        eject();
        open_to_process(1);
        grant();
        chk("dep3_new",   ifa.new_balance, 16'd1200);
        chk("dep3_old_b", ifb.old_balance, 16'd250);
        chk("dep3_new_b", ifb.new_balance, 16'd350);
        chk("dep3_dc_c",  ifc.deposit_completed, 16'd0);
        chk("dep3_old_c", ifc.old_balance, 16'hFF9B);
        chk("dep3_new_c", ifc.new_balance, 16'hFFFF);
        chk("dep3_ce_c",  ifc.card_eject, 16'd1);
        eject();

        // balance inquiry using transaction_selected alone
        open_to_process(2);
        chk("inq_tx", ifa.transaction, 16'b0100);
        grant();
        chk("inq_mini", ifa.mini_statement, 16'd1200);
        chk("inq_old",  ifa.old_balance, 16'd1200);
        chk("inq_new",  ifa.new_balance, 16'd1200);
        chk("inq_dc",   ifa.deposit_completed, 16'd0);
        chk("inq_mini_b", ifb.mini_statement, 16'd350);
        chk("inq_mini_c", ifc.mini_statement, 16'hFFFF);
        eject();

        // cancel in SELECT: eject without any transaction
        card_inserted = 1'b1;
        tick();
        pin_entered = 1'b1;
        tick();
        pin_entered = 1'b0;
        card_ejected = 1'b1;
        tick();
        chk("cancel_sel_ce", ifa.card_eject, 16'd1);
        chk("cancel_sel_tx", ifa.transaction, 16'd0);
        card_inserted = 1'b0;
        tick();
        card_ejected = 1'b0;
        chk("cancel_sel_idle", ifa.card_eject, 16'd0);

        // cancel beats grant in PROCESS
        open_to_process(0);
        card_ejected = 1'b1;
        grant();
        card_ejected = 1'b0;
        chk("cancel_proc_ce",  ifa.card_eject, 16'd1);
        chk("cancel_proc_wc",  ifa.withdrawal_completed, 16'd0);
        chk("cancel_proc_new", ifa.new_balance, 16'd1200);
        eject();

        // asynchronous reset in the middle of PROCESS
        open_to_process(0);
        chk("pre_rst_tx", ifa.transaction, 16'b0001);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_tx",   ifa.transaction, 16'd0);
        chk("mid_rst_ce",   ifa.card_eject, 16'd0);
        chk("mid_rst_new",  ifa.new_balance, 16'd1000);
        chk("mid_rst_old",  ifa.old_balance, 16'd1000);
        chk("mid_rst_mini", ifa.mini_statement, 16'd0);
        chk("mid_rst_new_b", ifb.new_balance, 16'd50);
        card_inserted = 1'b0;
        #3 reset = 1'b1;
        tick();
        chk("post_rst_ce",  ifa.card_eject, 16'd0);
        chk("post_rst_new", ifa.new_balance, 16'd1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
